// File: rtl/memtest_pkg.sv
// Shared types and constants for the memory-tester game controller.
// The sequence store holds seven one-hot symbols, newest in the low nibble.
package memtest_pkg;

    localparam int SYM_W     = 4;
    localparam int SEQ_W     = 28;
    localparam int MAX_LEVEL = 7;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 for a left-shifting Fibonacci register
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GEN      = 4'd1,
        ST_ADD      = 4'd2,
        ST_SETTLE   = 4'd3,
        ST_SHOW_ON  = 4'd4,
        ST_SHOW_OFF = 4'd5,
        ST_WAIT_IN  = 4'd6,
        ST_WIN      = 4'd7,
        ST_LOSE     = 4'd8
    } state_e;

    function automatic logic is_onehot4(input logic [SYM_W-1:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [SYM_W-1:0] sym_at(input logic [SEQ_W-1:0] seq,
                                                 input logic [2:0]       i);
        return seq[SYM_W*i +: SYM_W];
    endfunction

endpackage

// File: rtl/memtest_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; exposes the two bits used to pick a symbol.
module memtest_lfsr8
    import memtest_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       clock,
    input  logic       rst,
    output logic [1:0] rand_sel
);

    logic [7:0] lfsr_r;
    logic       fb_s;

    assign fb_s = ^(lfsr_r & LFSR_TAPS);

    // Advance every cycle out of reset
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= {lfsr_r[6:0], fb_s};
        end
    end

    assign rand_sel = lfsr_r[1:0];

endmodule

// File: rtl/memtest_sequencer.sv
// Memory-tester game controller: grows a random one-hot sequence in the external
// store, plays it back on the LEDs and checks the player's presses against it.
module memtest_sequencer
    import memtest_pkg::*;
#(
    parameter int unsigned FLASH_CYCLES   = 32'd25_000_000,
    parameter int unsigned GAP_CYCLES     = 32'd12_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 32'd0,
    parameter int unsigned MAX_LEVEL      = memtest_pkg::MAX_LEVEL,
    parameter logic [7:0]  LFSR_SEED      = memtest_pkg::LFSR_SEED
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             btn_valid,
    input  logic [SYM_W-1:0] btn_code,
    input  logic [SEQ_W-1:0] seq_q,
    output logic [SYM_W-1:0] flash_num,
    output logic             reg_enable,
    output logic             shl,
    output logic [SYM_W-1:0] led_code,
    output logic             led_on,
    output logic [2:0]       level,
    output logic             busy,
    output logic             win,
    output logic             lose
);

    localparam int unsigned MAX_FG  = (FLASH_CYCLES > GAP_CYCLES) ? FLASH_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_FG > TIMEOUT_CYCLES) ? MAX_FG : TIMEOUT_CYCLES;
    localparam int          CNT_W   = (MAX_CNT > 32'd1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] TO_LAST    =
        (TIMEOUT_CYCLES > 32'd0) ? CNT_W'(TIMEOUT_CYCLES - 32'd1) : CNT_ZERO;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [2:0]       LAST_LEVEL = 3'(MAX_LEVEL);

    state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0] timer_r;
    logic             timer_clr_s;
    logic [2:0]       idx_r, idx_nxt_s;
    logic [2:0]       pos_r, pos_nxt_s;
    logic [2:0]       level_r, level_nxt_s;
    logic             restart_r, restart_nxt_s;
    logic             btn_match_s;
    logic [1:0]       rand_sel_s;

    logic [SYM_W-1:0] flash_num_r;
    logic             reg_enable_r;
    logic             shl_r;
    logic [SYM_W-1:0] led_code_r;
    logic             led_on_r;
    logic             busy_r;
    logic             win_r;
    logic             lose_r;

    memtest_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock    (clock),
        .rst      (rst),
        .rand_sel (rand_sel_s)
    );

    // Next-state, phase timer and playback/press pointers
    always_comb begin
        state_nxt_s   = state_r;
        timer_clr_s   = 1'b1;
        idx_nxt_s     = idx_r;
        pos_nxt_s     = pos_r;
        level_nxt_s   = level_r;
        restart_nxt_s = 1'b0;
        btn_match_s   = is_onehot4(btn_code) && (btn_code == sym_at(seq_q, pos_r));

        case (state_r)
            ST_IDLE: begin
                level_nxt_s = 3'd0;
                if (start || restart_r) begin
                    state_nxt_s = ST_GEN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GEN: begin
                state_nxt_s = ST_ADD;
            end
            ST_ADD: begin
                // Playback starts at the oldest nibble, index new_level-1
                level_nxt_s = level_r + 3'd1;
                idx_nxt_s   = level_r;
                state_nxt_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_nxt_s = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (timer_r == FLASH_LAST) begin
                    state_nxt_s = ST_SHOW_OFF;
                end else begin
                    timer_clr_s = 1'b0;
                end
            end
            ST_SHOW_OFF: begin
                if (timer_r != GAP_LAST) begin
                    timer_clr_s = 1'b0;
                end else if (idx_r == 3'd0) begin
                    pos_nxt_s   = level_r - 3'd1;
                    state_nxt_s = ST_WAIT_IN;
                end else begin
                    idx_nxt_s   = idx_r - 3'd1;
                    state_nxt_s = ST_SHOW_ON;
                end
            end
            ST_WAIT_IN: begin
                // A press in the expiry cycle takes priority over the timeout
                if (btn_valid) begin
                    if (!btn_match_s) begin
                        state_nxt_s = ST_LOSE;
                    end else if (pos_r != 3'd0) begin
                        pos_nxt_s = pos_r - 3'd1;
                    end else if (level_r == LAST_LEVEL) begin
                        state_nxt_s = ST_WIN;
                    end else begin
                        state_nxt_s = ST_GEN;
                    end
                end else if (TIMEOUT_EN && (timer_r == TO_LAST)) begin
                    state_nxt_s = ST_LOSE;
                end else if (TIMEOUT_EN) begin
                    timer_clr_s = 1'b0;
                end else begin
                    timer_clr_s = 1'b1;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (start) begin
                    level_nxt_s   = 3'd0;
                    restart_nxt_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, timers and pointers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= CNT_ZERO;
            idx_r     <= 3'd0;
            pos_r     <= 3'd0;
            level_r   <= 3'd0;
            restart_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_clr_s ? CNT_ZERO : (timer_r + CNT_ONE);
            idx_r     <= idx_nxt_s;
            pos_r     <= pos_nxt_s;
            level_r   <= level_nxt_s;
            restart_r <= restart_nxt_s;
        end
    end

    // Registered outputs, aligned with the state they describe
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            flash_num_r  <= 4'd0;
            reg_enable_r <= 1'b0;
            shl_r        <= 1'b0;
            led_code_r   <= 4'd0;
            led_on_r     <= 1'b0;
            busy_r       <= 1'b0;
            win_r        <= 1'b0;
            lose_r       <= 1'b0;
        end else begin
            flash_num_r  <= (state_r == ST_GEN) ? (4'b0001 << rand_sel_s) : flash_num_r;
            reg_enable_r <= (state_nxt_s != ST_IDLE);
            shl_r        <= (state_nxt_s == ST_ADD);
            led_code_r   <= (state_nxt_s == ST_SHOW_ON) ? sym_at(seq_q, idx_nxt_s) : 4'd0;
            led_on_r     <= (state_nxt_s == ST_SHOW_ON);
            busy_r       <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_WIN) &&
                            (state_nxt_s != ST_LOSE);
            win_r        <= (state_nxt_s == ST_WIN);
            lose_r       <= (state_nxt_s == ST_LOSE);
        end
    end

    assign flash_num  = flash_num_r;
    assign reg_enable = reg_enable_r;
    assign shl        = shl_r;
    assign led_code   = led_code_r;
    assign led_on     = led_on_r;
    assign level      = level_r;
    assign busy       = busy_r;
    assign win        = win_r;
    assign lose       = lose_r;

endmodule

// File: tb/tb_memtest_sequencer.sv
// Self-checking bench for memtest_sequencer with a behavioural sequence store,
// an LFSR reference and a playback scoreboard filled on every shift.
module tb_memtest_sequencer;

    localparam int FLASH = 3;
    localparam int GAP   = 2;
    localparam int TMO   = 20;

    logic        clock = 1'b0;
    logic        rst;
    logic        start;
    logic        btn_valid;
    logic [3:0]  btn_code;
    logic [27:0] seq_q;
    logic [3:0]  flash_num;
    logic        reg_enable;
    logic        shl;
    logic [3:0]  led_code;
    logic        led_on;
    logic [2:0]  level;
    logic        busy;
    logic        win;
    logic        lose;

    int n_checks = 0;
    int n_errors = 0;
    int shl_count = 0;
    int pulse_count = 0;
    logic [3:0] golden[$];
    logic [3:0] exp_led_q[$];
    logic [7:0] lfsr_m, lfsr_prev;

    always #5 clock = ~clock;

    memtest_sequencer #(
        .FLASH_CYCLES   (FLASH),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .btn_valid  (btn_valid),
        .btn_code   (btn_code),
        .seq_q      (seq_q),
        .flash_num  (flash_num),
        .reg_enable (reg_enable),
        .shl        (shl),
        .led_code   (led_code),
        .led_on     (led_on),
        .level      (level),
        .busy       (busy),
        .win        (win),
        .lose       (lose)
    );

    // Behavioural sequence store
    always_ff @(posedge clock or negedge rst) begin
        if (!rst)            seq_q <= 28'd0;
        else if (!reg_enable) seq_q <= 28'd0;
        else if (shl)        seq_q <= {seq_q[23:0], flash_num};
        else                 seq_q <= seq_q;
    end

    // Reference LFSR x^8+x^6+x^5+x^4+1 and its previous-cycle value
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            lfsr_m    <= 8'hA5;
            lfsr_prev <= 8'hA5;
        end else begin
            lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            lfsr_prev <= lfsr_m;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Monitor: capture golden symbols on shl and score the LED playback
    initial begin : monitor
        logic shl_prev;
        logic led_prev;
        int   run;
        shl_prev = 1'b0;
        led_prev = 1'b0;
        run      = 0;
        forever begin
            @(negedge clock);
            if (!rst) begin
                shl_prev = 1'b0;
                led_prev = 1'b0;
                run      = 0;
            end else begin
                if (shl) begin
                    check_val("shl_single", 32'(shl_prev), 32'd0);
                    check_val("flash_num", 32'(flash_num), 32'(4'b0001 << lfsr_prev[1:0]));
                    golden.push_back(flash_num);
                    foreach (golden[i]) exp_led_q.push_back(golden[i]);
                    shl_count++;
                end
                if (led_on && !led_prev) begin
                    pulse_count++;
                    run = 0;
                    if (exp_led_q.size() == 0) check_val("led_extra", 32'(exp_led_q.size()), 32'd1);
                    else check_val("led_code", 32'(led_code), 32'(exp_led_q.pop_front()));
                end
                if (led_on) run++;
                if (!led_on && led_prev) check_val("led_len", 32'(run), 32'(FLASH));
                shl_prev = shl;
                led_prev = led_on;
            end
        end
    end

    task automatic do_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clock); btn_valid = 1'b1; btn_code = c;
        @(negedge clock); btn_valid = 1'b0; btn_code = 4'd0;
    endtask

    // Returns on the clock edge that enters WAIT_IN after the round's playback
    task automatic wait_wait_in(input int shl_target);
        int guard;
        guard = 0;
        @(negedge clock); #1;
        while (!(shl_count >= shl_target && exp_led_q.size() == 0 && !led_on) && guard < 500) begin
            @(negedge clock); #1;
            guard++;
        end
        check_val("wait_in_reached", 32'(guard < 500), 32'd1);
        @(posedge clock);
        @(posedge clock);
    endtask

    task automatic wait_led_on(input int shl_target);
        int guard;
        guard = 0;
        @(negedge clock); #1;
        while (!(shl_count >= shl_target && led_on) && guard < 500) begin
            @(negedge clock); #1;
            guard++;
        end
        check_val("led_on_reached", 32'(guard < 500), 32'd1);
    endtask

    task automatic play_round(input int r, input int base);
        int pc0;
        pc0 = pulse_count;
        wait_wait_in(base + r);
        check_val("round_level", 32'(level), 32'(r));
        check_val("round_pulses", 32'(pulse_count - pc0), 32'(r));
        check_val("round_busy", 32'(busy), 32'd1);
        for (int i = 0; i < r; i++) press(golden[i]);
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin : main
        int base;
        logic [27:0] exp_seq;
        rst = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_code = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock); rst = 1'b1;

        // 1: idle after reset
        repeat (10) @(negedge clock);
        #1;
        check_val("rst_outputs", 32'({flash_num, reg_enable, shl, led_code, led_on, level, busy, win, lose}), 32'd0);
        check_val("rst_no_shl", 32'(shl_count), 32'd0);

        // 2: first round timing
        golden.delete(); exp_led_q.delete();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0; #1;
        check_val("gen_shl", 32'(shl), 32'd0);
        check_val("gen_busy", 32'(busy), 32'd1);
        check_val("gen_reg_en", 32'(reg_enable), 32'd1);
        @(negedge clock); #1;
        check_val("add_shl", 32'(shl), 32'd1);
        @(negedge clock); #1;
        check_val("settle_level", 32'(level), 32'd1);

        // 3: full game to WIN
        for (int r = 1; r <= 7; r++) play_round(r, 0);
        #1;
        check_val("win", 32'(win), 32'd1);
        check_val("win_busy", 32'(busy), 32'd0);
        check_val("win_level", 32'(level), 32'd7);
        exp_seq = 28'd0;
        for (int i = 0; i < 7; i++) exp_seq = {exp_seq[23:0], golden[i]};
        check_val("win_store", 32'(seq_q), 32'(exp_seq));
        repeat (10) @(negedge clock);
        #1;
        check_val("win_shl_count", 32'(shl_count), 32'd7);
        check_val("win_hold", 32'({win, reg_enable}), 32'd3);

        // 4: wrong press at level 3
        golden.delete(); exp_led_q.delete();
        base = shl_count;
        do_start(); #1;
        check_val("restart_idle", 32'({reg_enable, win, busy, level}), 32'd0);
        play_round(1, base);
        play_round(2, base);
        wait_wait_in(base + 3);
        press(golden[0]);
        press(4'b0011);
        #1;
        check_val("lose", 32'(lose), 32'd1);
        check_val("lose_level", 32'(level), 32'd3);
        check_val("lose_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clock);
        #1;
        check_val("lose_no_shl", 32'(shl_count), 32'(base + 3));

        // 5a: timeout
        golden.delete(); exp_led_q.delete();
        base = shl_count;
        do_start();
        wait_wait_in(base + 1);
        repeat (TMO - 1) @(posedge clock);
        #1;
        check_val("tmo_before", 32'(lose), 32'd0);
        @(posedge clock); #1;
        check_val("tmo_expire", 32'(lose), 32'd1);

        // 5b: press in the expiry cycle is accepted
        golden.delete(); exp_led_q.delete();
        base = shl_count;
        do_start();
        wait_wait_in(base + 1);
        repeat (TMO - 1) @(posedge clock);
        press(golden[0]);
        #1;
        check_val("tmo_press_lose", 32'(lose), 32'd0);
        check_val("tmo_press_busy", 32'(busy), 32'd1);
        play_round(2, base);

        // 6: ignored press/start during playback, then reset mid-playback
        wait_led_on(base + 3);
        press(4'b1111);
        do_start();
        wait_wait_in(base + 3);
        check_val("ign_level", 32'(level), 32'd3);
        check_val("ign_lose", 32'(lose), 32'd0);
        check_val("ign_shl", 32'(shl_count), 32'(base + 3));
        for (int i = 0; i < 3; i++) press(golden[i]);
        wait_led_on(base + 4);
        check_val("l4_level", 32'(level), 32'd4);
        #2 rst = 1'b0;
        #1;
        check_val("midrst_outputs", 32'({flash_num, reg_enable, shl, led_code, led_on, level, busy, win, lose}), 32'd0);
        check_val("midrst_store", 32'(seq_q), 32'd0);
        @(negedge clock);
        @(posedge clock); #1 rst = 1'b1;
        golden.delete(); exp_led_q.delete();
        repeat (5) @(negedge clock);
        #1;
        check_val("post_rst_idle", 32'({busy, reg_enable, level}), 32'd0);
        base = shl_count;
        do_start();
        play_round(1, base);
        wait_wait_in(base + 2);
        check_val("post_rst_level", 32'(level), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memtest_sequencer.md
Name: memtest_sequencer

Overview:
Game controller for the memory-tester's 28-bit sequence store (seven 4-bit one-hot symbols, newest in bits [3:0]).
- Each round it generates a pseudo-random symbol and shifts it into the store.
- It plays the whole stored sequence, oldest first, on the LED outputs.
- It then checks player button presses against the stored sequence.
- It advances level 1..7 and ends in WIN or LOSE.

It sits between the button/LED front end and the shift-register store, and drives that store's flash_num, reg_enable and shl inputs.

Parameters:
FLASH_CYCLES, 25_000_000, clock cycles each symbol is lit during playback (>=1)
GAP_CYCLES, 12_500_000, dark cycles between/after playback symbols (>=1)
TIMEOUT_CYCLES, 0, max cycles waiting for each press; 0 disables timeout
MAX_LEVEL, 7, symbols to win; fixed 7 = 28/4
LFSR_SEED, 8'hA5, nonzero LFSR reset value

Ports:
clock  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin new game
btn_valid  in  1  one-cycle pulse, player pressed a button
btn_code  in  4  one-hot button code, valid with btn_valid
seq_q  in  28  store contents (Q of shift register)
flash_num  out  4  symbol to shift into store
reg_enable  out  1  store enable; 0 clears store on next clock
shl  out  1  one-cycle shift strobe to store
led_code  out  4  symbol being displayed
led_on  out  1  playback LED strobe
level  out  3  current sequence length 0..7
busy  out  1  1 in any state except IDLE/WIN/LOSE
win  out  1  held high in WIN
lose  out  1  held high in LOSE

Behaviour:
- Reset (async, rst=0): state=IDLE; flash_num=0, reg_enable=0, shl=0, led_code=0, led_on=0, level=0, win=0, lose=0, all counters 0, LFSR=LFSR_SEED.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, free-running every cycle out of reset.
- States and transitions:
  - IDLE: reg_enable=0, so the store is held cleared. start -> GEN.
  - GEN (1 cycle): reg_enable=1; flash_num <= 4'b0001 << lfsr[1:0] -> ADD.
  - ADD (1 cycle): shl=1; level <= level+1; idx <= new level-1 -> SETTLE.
  - SETTLE (1 cycle): store output becomes valid -> SHOW_ON.
  - SHOW_ON: led_on=1, led_code=seq_q[4*idx+:4] for FLASH_CYCLES -> SHOW_OFF.
  - SHOW_OFF: led_on=0 for GAP_CYCLES; if idx==0 -> WAIT_IN (pos <= level-1), else idx-- -> SHOW_ON.
  - WAIT_IN: on btn_valid compare btn_code with seq_q[4*pos+:4].
    - Mismatch -> LOSE.
    - Match with pos>0: pos--, timeout counter cleared.
    - Match with pos==0: if level==MAX_LEVEL -> WIN, else -> GEN.
    - Timeout (if enabled) -> LOSE.
  - WIN / LOSE: output held; reg_enable stays 1, so the sequence is preserved for display/debug. start -> IDLE for 1 cycle, then GEN. The clear happens because reg_enable=0 in IDLE.
- reg_enable=1 in every state except IDLE. shl is high only in ADD, never two consecutive cycles.
- Press order is oldest first: the first press matches nibble level-1, the last press matches nibble 0.
- Boundary conditions:
  - btn_valid outside WAIT_IN is ignored, including during playback.
  - start while busy is ignored.
  - btn_code not one-hot never matches -> LOSE.
  - btn_valid and timeout expiry in the same cycle: the press wins.
  - Level never exceeds 7; no shift occurs after level 7.
  - rst mid-game returns to IDLE immediately. The store clears via its own reset and reg_enable=0.
- Counters are wide enough for the largest of FLASH/GAP/TIMEOUT; there is no wrap-around inside a phase.

Decomposition:
- Package memtest_pkg:
  - State encoding (IDLE, GEN, ADD, SETTLE, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE).
  - SYM_W=4, SEQ_W=28, MAX_LEVEL=7, LFSR taps and seed.
- Sub-module memtest_lfsr8: free-running LFSR, async active-low reset to seed.
- The FSM, timers and compare stay in memtest_sequencer.

Test Plan:
Bench setup: FLASH_CYCLES=3, GAP_CYCLES=2, TIMEOUT_CYCLES=20, with a behavioural store model; flash_num captured on each shl is the golden sequence.
1. Reset then idle 10 cycles -> all outputs 0, reg_enable=0, no shl.
2. start -> exactly one shl 3 cycles later (GEN, ADD), level=1, flash_num one-hot. One led_on pulse of 3 cycles with led_code=golden[0], then busy in WAIT_IN.
3. Play 7 rounds, pressing the golden sequence oldest first each round -> level steps 1..7, playback lengths 1..7 in correct order, win=1, busy=0, seq_q holds 7 symbols.
4. Level 3 round, second press wrong (or 4'b0011) -> lose=1 next cycle, level stays 3, no further shl.
5. WAIT_IN with no press for 20 cycles -> lose=1. Repeat with btn_valid in the same cycle as expiry -> press is accepted.
6. rst pulsed low during SHOW_ON at level 4 -> immediate IDLE, outputs 0, store clears. Press during playback and start while busy both produce no effect.
